// File: rtl/sha256_pkg.sv
// Shared word types and adder slicing defaults for the SHA-256 datapath.
package sha256_pkg;
  localparam int WORD_W      = 32;
  localparam int CPA_CHUNK_W = 8;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/cpa_stage.sv
// One carry-propagate adder slice: registered result chunk, carry-out and valid.
module cpa_stage
  import sha256_pkg::*;
#(
  parameter int CHUNK_W = CPA_CHUNK_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);
  logic [CHUNK_W:0] add;

  assign add = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      sum       <= add[CHUNK_W-1:0];
      cout      <= add[CHUNK_W];
    end
  end
endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into one binary word through a
// chunked, pipelined carry-propagate adder with a single global stall.
module csa_resolver
  import sha256_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int CHUNK_W = CPA_CHUNK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);
  localparam int STAGES = WIDTH / CHUNK_W;

  logic             adv;
  logic [WIDTH-1:0] b;
  logic [STAGES:0]  vld_pipe;
  logic [STAGES:0]  carry;

  // Shift drops c_in's MSB: its weight 2^WIDTH is outside the result.
  assign b           = c_in << 1;
  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;
  assign vld_pipe[0] = in_valid;
  assign carry[0]    = 1'b0;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = WIDTH - k * CHUNK_W;   // chunks k..STAGES-1 still pending
    localparam int DW = (k + 1) * CHUNK_W;     // chunks 0..k already resolved
    logic [SW-1:0]      s_skew;
    logic [SW-1:0]      b_skew;
    logic [CHUNK_W-1:0] sum;
    logic [DW-1:0]      acc;

    if (k == 0) begin : g_head
      assign s_skew = s_in;
      assign b_skew = b;
      assign acc    = sum;
    end else begin : g_body
      logic [DW-CHUNK_W-1:0] lo;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s_skew <= '0;
          b_skew <= '0;
          lo     <= '0;
        end else if (adv) begin
          s_skew <= g_stage[k-1].s_skew[SW+CHUNK_W-1:CHUNK_W];
          b_skew <= g_stage[k-1].b_skew[SW+CHUNK_W-1:CHUNK_W];
          lo     <= g_stage[k-1].acc;
        end
      end

      assign acc = {sum, lo};
    end

    cpa_stage #(.CHUNK_W(CHUNK_W)) u_cpa (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (vld_pipe[k]),
      .a         (s_skew[CHUNK_W-1:0]),
      .b         (b_skew[CHUNK_W-1:0]),
      .cin       (carry[k]),
      .out_valid (vld_pipe[k+1]),
      .sum       (sum),
      .cout      (carry[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_cout  = carry[STAGES];
  assign out_sum   = g_stage[STAGES-1].acc;
endmodule

// File: tb/tb_csa_resolver.sv
// Randomized self-checking bench for csa_resolver against an arithmetic scoreboard.
module tb_csa_resolver;
  import sha256_pkg::*;

  localparam int STAGES = WORD_W / CPA_CHUNK_W;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b1;
  word_t s_in = '0;
  word_t c_in = '0;
  logic  in_ready;
  logic  out_valid;
  word_t out_sum;
  logic  out_cout;

  csa_resolver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  int acc_cyc[$];
  int emit_cyc[$];

  // Value of s + 2*c where the carry MSB carries weight 2^32 and is lost.
  function automatic logic [32:0] ref_add(word_t s, word_t c);
    return 33'(s) + 33'(c % 32'h8000_0000) * 33'd2;
  endfunction

  // Inputs are set at the falling edge; handshakes are sampled 1 ns later.
  task automatic cycle();
    #1;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(s_in, c_in));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        obs_q.push_back({out_cout, out_sum});
        emit_cyc.push_back(cyc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); acc_cyc.delete(); emit_cyc.delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) cycle();
    for (int i = 0; i < STAGES + 2; i++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    cycle(); cycle();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 0", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %0b want 0", out_cout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    rst_n = 1'b1;
    cycle();
    clear_q();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    s_in = 32'h0000_00FF; c_in = 32'h0000_0001; in_valid = 1'b1;
    cycle();
    drain();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== {1'b0, 32'h0000_0101}) begin errors++; $display("FAIL basic_value got %h want 0_00000101", obs_q[0]); end
      checks++; if (emit_cyc[0] - acc_cyc[0] != STAGES) begin errors++; $display("FAIL basic_latency got %0d want %0d", emit_cyc[0] - acc_cyc[0], STAGES); end
    end
    clear_q();
  endtask

  task automatic test_ripple();
    word_t       s_v[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    word_t       c_v[3] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
    logic [32:0] want[3] = '{{1'b0, 32'hFFFF_FFFF}, {1'b1, 32'h0000_0001}, {1'b0, 32'h0000_0000}};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_in = s_v[i]; c_in = c_v[i]; in_valid = 1'b1;
      cycle();
    end
    drain();
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL ripple_count got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL ripple_%0d got %h want %h", i, obs_q[i], want[i]); end
    end
    clear_q();
  endtask

  task automatic test_sha_stream();
    word_t x, y, z;
    x = 32'h6A09_E667; y = 32'hBB67_AE85; z = 32'h3C6E_F372;
    out_ready = 1'b1;
    s_in = x ^ y ^ z; c_in = (x & y) | (x & z) | (y & z); in_valid = 1'b1;
    cycle();
    drain();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL sha_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0][31:0] !== 32'h61E0_885E) begin errors++; $display("FAIL sha_sum got %h want 61e0885e", obs_q[0][31:0]); end
      checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL sha_cout got %h want %h", obs_q[0], exp_q[0]); end
    end
    clear_q();
    for (int i = 0; i < 8; i++) begin
      x = $urandom(); y = $urandom(); z = $urandom();
      s_in = x ^ y ^ z; c_in = (x & y) | (x & z) | (y & z); in_valid = 1'b1;
      cycle();
    end
    drain();
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL stream_count got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      if (i > 0) begin
        checks++;
        if (emit_cyc[i] != emit_cyc[i-1] + 1) begin errors++; $display("FAIL stream_gap_%0d got %0d want %0d", i, emit_cyc[i], emit_cyc[i-1] + 1); end
      end
    end
    clear_q();
  endtask

  task automatic test_stall();
    word_t held_sum;
    logic  held_cout;
    out_ready = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      s_in = $urandom(); c_in = $urandom(); in_valid = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
    #1;
    held_sum = out_sum; held_cout = out_cout;
    for (int i = 0; i < 3; i++) begin
      s_in = $urandom(); c_in = $urandom(); in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d got %0b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d got %0b want 1", i, out_valid); end
      checks++; if ({out_cout, out_sum} !== {held_cout, held_sum}) begin errors++; $display("FAIL stall_hold_%0d got %h want %h", i, {out_cout, out_sum}, {held_cout, held_sum}); end
      cycle();
    end
    drain();
    checks++; if (obs_q.size() != STAGES) begin errors++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), STAGES); end
    for (int i = 0; i < STAGES && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_item_%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    clear_q();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      s_in = $urandom(); c_in = $urandom();
      cycle();
    end
    drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_item_%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    clear_q();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_in = $urandom(); c_in = $urandom(); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL flush_sum got %h want 0", out_sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    clear_q();
    for (int i = 0; i < 10; i++) cycle();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL flush_stale got %0d want 0", obs_q.size()); end
    s_in = 32'h1234_5678; c_in = 32'h0F0F_0F0F; in_valid = 1'b1;
    cycle();
    drain();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL flush_after_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL flush_after_value got %h want %h", obs_q[0], exp_q[0]); end
    end
    clear_q();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_ripple();
    test_sha_stream();
    test_stall();
    test_random();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
